// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide controller.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_RUN,
    ST_DONE
  } md_state_e;

  // Quotient reported for any divide by zero.
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  localparam int unsigned MUL_LAT_DEFAULT = 2;
  localparam int unsigned DIV_STEPS       = 32;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [5:0]  step;
  logic [63:0] part;
  logic [31:0] dvsr;
  logic [32:0] trial;
  logic [63:0] part_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial     = part[63:31] - {1'b0, dvsr};
    part_next = '0;
    if (!trial[32]) begin
      part_next = {trial[31:0], part[30:0], 1'b1};
    end else begin
      part_next = {part[62:31], part[30:0], 1'b0};
    end
  end

  // Step counter and partial-remainder register.
  always_ff @(posedge clk) begin
    if (clear) begin
      busy <= 1'b0;
      step <= '0;
      part <= '0;
      dvsr <= '0;
    end else if (start) begin
      busy <= 1'b1;
      step <= '0;
      part <= {32'd0, dividend};
      dvsr <= divisor;
    end else if (busy) begin
      part <= part_next;
      step <= step + 6'd1;
      if (step == 6'(DIV_STEPS - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  // done marks the cycle performing the final step; results are valid from the next cycle.
  assign done      = busy && (step == 6'(DIV_STEPS - 1));
  assign quotient  = part[31:0];
  assign remainder = part[63:32];

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencing controller: drives an external pipelined multiplier,
// runs the iterative divider, stalls EX for multi-cycle ops and owns HI/LO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        stallreq,
  output logic        done,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] LAT_LAST = 3'(MUL_LAT - 1);

  md_state_e   state;
  logic [2:0]  lat_cnt;
  logic        is_mul;
  logic        div_zero;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_raw;

  logic        op_is_mul;
  logic        op_is_div;
  logic        op_signed_div;
  logic        div_start;
  logic        div_clear;
  logic        div_busy;
  logic        div_last;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic [31:0] q_fixed;
  logic [31:0] r_fixed;

  assign op_is_mul     = (op == MD_MULT) || (op == MD_MULTU);
  assign op_is_div     = (op == MD_DIV) || (op == MD_DIVU);
  assign op_signed_div = (op == MD_DIV);

  assign div_clear = rst | annul;
  assign div_start = (state == ST_IDLE) && op_valid && !annul && op_is_div && (src_b != '0);

  div_iter u_div (
    .clk       (clk),
    .clear     (div_clear),
    .start     (div_start),
    .dividend  (mag32(src_a, op_signed_div)),
    .divisor   (mag32(src_b, op_signed_div)),
    .busy      (div_busy),
    .done      (div_last),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Sign post-correction: quotient negative iff signs differed, remainder follows the dividend.
  always_comb begin
    q_fixed = neg_q ? (~div_quotient + 32'd1) : div_quotient;
    r_fixed = neg_r ? (~div_remainder + 32'd1) : div_remainder;
  end

  // Stall, completion pulse and write-back values; annul and reset silence all of them.
  always_comb begin
    stallreq = 1'b0;
    done     = 1'b0;
    res_hi   = '0;
    res_lo   = '0;
    if (!rst && !annul) begin
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (op_is_mul || op_is_div) begin
              stallreq = 1'b1;
            end else if (op == MD_MTHI) begin
              done   = 1'b1;
              res_hi = src_a;
              res_lo = lo;
            end else if (op == MD_MTLO) begin
              done   = 1'b1;
              res_hi = hi;
              res_lo = src_a;
            end
          end
        end
        ST_MUL_WAIT: stallreq = 1'b1;
        ST_DIV_RUN:  stallreq = div_busy;
        ST_DONE: begin
          done = 1'b1;
          if (is_mul) begin
            res_hi = mul_result[63:32];
            res_lo = mul_result[31:0];
          end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = DIV_ZERO_LO;
          end else begin
            res_hi = r_fixed;
            res_lo = q_fixed;
          end
        end
      endcase
    end
  end

  // Sequencing FSM plus operand latches and the architectural HI/LO pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hi         <= '0;
      lo         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      lat_cnt    <= '0;
      is_mul     <= 1'b0;
      div_zero   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      a_raw      <= '0;
    end else if (annul) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (op_is_mul) begin
              mul_a      <= src_a;
              mul_b      <= src_b;
              mul_signed <= (op == MD_MULT);
              lat_cnt    <= '0;
              is_mul     <= 1'b1;
              state      <= ST_MUL_WAIT;
            end else if (op_is_div) begin
              is_mul   <= 1'b0;
              a_raw    <= src_a;
              div_zero <= (src_b == '0);
              neg_q    <= op_signed_div && (src_a[31] ^ src_b[31]);
              neg_r    <= op_signed_div && src_a[31];
              state    <= (src_b == '0) ? ST_DONE : ST_DIV_RUN;
            end else if (op == MD_MTHI) begin
              hi <= src_a;
            end else if (op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_DIV_RUN: begin
          if (div_last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with a behavioural pipelined multiplier.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        annul = 1'b0;
  logic [31:0] mul_a, mul_b;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        stallreq, done;
  logic [31:0] res_hi, res_lo, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_hilo = '0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .annul      (annul),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .stallreq   (stallreq),
    .done       (done),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier with MUL_LAT register stages.
  logic [63:0] pipe [MUL_LAT];
  logic [63:0] prod;
  always_comb begin
    if (mul_signed) prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else            prod = {32'd0, mul_a} * {32'd0, mul_b};
  end
  always_ff @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_result = pipe[MUL_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    sa  = $signed(a);
    sbv = $signed(b);
    case (o)
      MD_MULT:  return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Present an op at the current cycle (called just after a rising edge);
  // checks the stall window, done cycle, write-back values and HI/LO after.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int stall_last, input int done_cyc, input logic [63:0] exp,
                        input bit b2b);
    logic [63:0] e;
    bit got_done;
    e = exp;
    sb_q.push_back(exp);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    got_done = 0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(negedge clk);
      check("stall", 64'(stallreq), 64'(c <= stall_last));
      if (done) begin
        check("done_cycle", 64'(c), 64'(done_cyc));
        e = sb_q.pop_front();
        check("res", {res_hi, res_lo}, e);
        got_done = 1;
      end
      @(posedge clk); #1;
    end
    check("timeout", 64'(got_done), 64'd1);
    if (!got_done && sb_q.size() > 0) void'(sb_q.pop_front());
    last_hilo = e;
    if (!b2b) begin
      op_valid = 1'b0; op = MD_NONE;
      @(negedge clk);
      check("hilo", {hi, lo}, e);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_mul", {mul_a, mul_b}, 64'd0);
    check("rst_ctl", {61'd0, mul_signed, stallreq, done}, 64'd0);
    check("rst_res", {res_hi, res_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // mult in the first cycle after reset
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, MUL_LAT, MUL_LAT + 1, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op(MD_DIVU, 32'd100, 32'd7, 32, 33, {32'd2, 32'd14}, 0);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32, 33, {32'd0, 32'h8000_0000}, 0);
    run_op(MD_DIVU, 32'd5, 32'd0, 0, 1, {32'd5, 32'hFFFF_FFFF}, 0);
    // mthi then mtlo back-to-back: mtlo must see the new hi
    run_op(MD_MTHI, 32'h1234_5678, 32'd0, -1, 0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
    run_op(MD_MTLO, 32'hCAFE_F00D, 32'd0, -1, 0, {32'h1234_5678, 32'hCAFE_F00D}, 0);
    // back-to-back multu then signed divide by zero
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_LAT + 1, 64'hFFFF_FFFE_0000_0001, 1);
    run_op(MD_DIV, 32'h8000_0000, 32'd0, 0, 1, {32'h8000_0000, 32'hFFFF_FFFF}, 0);

    // Annul a running divide in cycle 10
    op_valid = 1'b1; op = MD_DIV; src_a = 32'd1000; src_b = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("annul_pre_stall", 64'(stallreq), 64'd1);
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stallreq), 64'd0);
    check("annul_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; op_valid = 1'b0; op = MD_NONE;
    @(negedge clk);
    check("post_annul_done", 64'(done), 64'd0);
    check("post_annul_hilo", {hi, lo}, last_hilo);
    @(posedge clk); #1;
    run_op(MD_DIVU, 32'd9, 32'd3, 32, 33, {32'd0, 32'd3}, 0);

    // Mixed random ops against the behavioural model
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int sl, dc;
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if (i == 3) b = '0;
      if (i == 4) b = 32'($urandom_range(1, 15));
      if (o == MD_MULT || o == MD_MULTU) begin sl = MUL_LAT; dc = MUL_LAT + 1; end
      else if (b == 0) begin sl = 0; dc = 1; end
      else begin sl = 32; dc = 33; end
      run_op(o, a, b, sl, dc, model(o, a, b), 0);
    end

    // Reset in the middle of a divide
    run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, MUL_LAT, MUL_LAT + 1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    op_valid = 1'b1; op = MD_DIVU; src_a = 32'd1000; src_b = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0; op = MD_NONE;
    @(negedge clk);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_mul", {mul_a, mul_b}, 64'd0);
    check("midrst_ctl", {61'd0, mul_signed, stallreq, done}, 64'd0);
    check("midrst_res", {res_hi, res_lo}, 64'd0);
    @(posedge clk); #1;
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, MUL_LAT, MUL_LAT + 1, 64'h0000_0001_0000_0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
